// File: rtl/jk_pkg.sv
// Shared definitions for the J-K target driver: FSM states and 2-bit {j,k} command codes.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        CHECK = 2'b10
    } state_t;

    // Command codes are packed as {j, k}
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_target_driver_if.sv
// Target-word valid/ready handshake between a requester and the J-K target driver.
interface jk_target_driver_if #(
    parameter int WIDTH = 4
) ();

    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;
    logic             toggle_mode;

    modport master (
        output tgt_valid,
        output tgt_data,
        output toggle_mode,
        input  tgt_ready
    );

    modport slave (
        input  tgt_valid,
        input  tgt_data,
        input  toggle_mode,
        output tgt_ready
    );

endinterface

// File: rtl/jk_excite.sv
// Per-bit J/K encoder: picks the command that moves current q toward target t.
module jk_excite
    import jk_pkg::*;
(
    input  logic q,
    input  logic t,
    input  logic toggle_mode,
    output logic j,
    output logic k
);

    logic [1:0] w_cmd;

    always_comb begin
        w_cmd = JK_HOLD;
        if (q != t) begin
            if (toggle_mode) w_cmd = JK_TOGGLE;
            else if (t)      w_cmd = JK_SET;
            else             w_cmd = JK_RESET;
        end
    end

    assign j = w_cmd[1];
    assign k = w_cmd[0];

endmodule

// File: rtl/jk_target_driver.sv
// Drives a J-K flip-flop bank toward a target word, retrying until q matches or the budget is spent.
module jk_target_driver
    import jk_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_TRIES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    jk_target_driver_if.slave tgt,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int              TW        = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0]   TRIES_MAX = TW'(MAX_TRIES);

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_tgt, w_tgt_nx;
    logic             r_tog, w_tog_nx;
    logic [TW-1:0]    r_tries, w_tries_nx;
    logic [WIDTH-1:0] r_j, r_k, w_j_nx, w_k_nx;
    logic             r_done, r_err, w_done_nx, w_err_nx;

    logic [WIDTH-1:0] w_t_src;
    logic             w_tog_src;
    logic [WIDTH-1:0] w_j_enc, w_k_enc;

    // j/k are registered, so the encoder looks at the target that will be in force during DRIVE
    assign w_t_src   = (r_state == IDLE) ? tgt.tgt_data    : r_tgt;
    assign w_tog_src = (r_state == IDLE) ? tgt.toggle_mode : r_tog;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_excite
        jk_excite u_excite (
            .q           (q_in[gi]),
            .t           (w_t_src[gi]),
            .toggle_mode (w_tog_src),
            .j           (w_j_enc[gi]),
            .k           (w_k_enc[gi])
        );
    end

    always_comb begin
        w_state_nx = r_state;
        w_tgt_nx   = r_tgt;
        w_tog_nx   = r_tog;
        w_tries_nx = r_tries;
        w_j_nx     = '0;
        w_k_nx     = '0;
        w_done_nx  = 1'b0;
        w_err_nx   = 1'b0;
        case (r_state)
            IDLE: begin
                if (tgt.tgt_valid) begin
                    w_tgt_nx   = tgt.tgt_data;
                    w_tog_nx   = tgt.toggle_mode;
                    w_tries_nx = '0;
                    w_j_nx     = w_j_enc;
                    w_k_nx     = w_k_enc;
                    w_state_nx = DRIVE;
                end
            end
            DRIVE: begin
                if (r_tries != TRIES_MAX) w_tries_nx = r_tries + 1'b1;
                w_state_nx = CHECK;
            end
            CHECK: begin
                if (q_in == r_tgt) begin
                    w_done_nx  = 1'b1;
                    w_state_nx = IDLE;
                end else if (r_tries == TRIES_MAX) begin
                    w_err_nx   = 1'b1;
                    w_state_nx = IDLE;
                end else begin
                    w_j_nx     = w_j_enc;
                    w_k_nx     = w_k_enc;
                    w_state_nx = DRIVE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tgt   <= '0;
            r_tog   <= 1'b0;
            r_tries <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_tgt   <= w_tgt_nx;
            r_tog   <= w_tog_nx;
            r_tries <= w_tries_nx;
            r_j     <= w_j_nx;
            r_k     <= w_k_nx;
            r_done  <= w_done_nx;
            r_err   <= w_err_nx;
        end
    end

    assign tgt.tgt_ready = (r_state == IDLE);
    assign busy          = (r_state != IDLE);
    assign j             = r_j;
    assign k             = r_k;
    assign done          = r_done;
    assign err           = r_err;

endmodule

// File: tb/tb_jk_target_driver.sv
// Bench for jk_target_driver: a behavioural JK bank closes the loop; a transfer-level model predicts j/k and outcome.
module tb_jk_target_driver;

    localparam int W  = 4;
    localparam int MT = 3;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] q_in, j, k;
    logic         busy, done, err;
    logic [W-1:0] bank_q;
    logic         bank_clr;
    logic [W-1:0] stuck;

    int n_vec = 0;
    int n_mis = 0;

    jk_target_driver_if #(.WIDTH(W)) u_if ();

    jk_target_driver #(.WIDTH(W), .MAX_TRIES(MT)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tgt   (u_if),
        .q_in  (q_in),
        .j     (j),
        .k     (k),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flip-flop bank under excitation; stuck bits read back as 0
    always @(posedge clk) begin
        if (bank_clr) bank_q <= '0;
        else          bank_q <= (j & ~bank_q) | (~k & bank_q);
    end
    assign q_in = bank_q & ~stuck;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model one J-K flip-flop responding to a command
    function automatic logic jk_next(input logic q, input logic jj, input logic kk);
        if (jj && kk) return ~q;
        if (jj)       return 1'b1;
        if (kk)       return 1'b0;
        return q;
    endfunction

    // One transfer: predict every DRIVE command and the outcome, then follow the DUT cycle by cycle.
    task automatic xfer(input logic [W-1:0] t, input logic tog, input bit hold);
        logic [W-1:0] qb, qv;
        logic [W-1:0] ej [1:MT];
        logic [W-1:0] ek [1:MT];
        int           n;
        bit           ok;
        qb = bank_q;
        ok = 0;
        n  = 0;
        for (int i = 1; i <= MT; i++) begin
            if (!ok) begin
                n  = i;
                qv = qb & ~stuck;
                for (int b = 0; b < W; b++) begin
                    ej[i][b] = 1'b0;
                    ek[i][b] = 1'b0;
                    if (qv[b] != t[b]) begin
                        ej[i][b] = tog | t[b];
                        ek[i][b] = tog | ~t[b];
                    end
                end
                for (int b = 0; b < W; b++) qb[b] = jk_next(qb[b], ej[i][b], ek[i][b]);
                if ((qb & ~stuck) == t) ok = 1;
            end
        end

        u_if.tgt_valid   = 1'b1;
        u_if.tgt_data    = t;
        u_if.toggle_mode = tog;
        chk("ready_at_offer", 32'(u_if.tgt_ready), 32'd1);
        @(posedge clk);
        for (int c = 1; c <= 2 * n + 1; c++) begin
            @(negedge clk);
            if (hold) begin
                u_if.tgt_data    = W'($urandom);
                u_if.toggle_mode = 1'($urandom);
            end else if (c == 1) begin
                u_if.tgt_valid = 1'b0;
            end
            if (c == 2 * n + 1) begin
                chk("end_done_err", {30'd0, done, err}, {30'd0, ok, !ok});
                chk("end_busy_ready", {30'd0, busy, u_if.tgt_ready}, 32'b01);
                chk("end_jk", {24'd0, j, k}, 32'd0);
                chk("end_bank", 32'(bank_q), 32'(qb));
            end else if (c % 2 == 1) begin
                chk("drive_j", 32'(j), 32'(ej[(c + 1) / 2]));
                chk("drive_k", 32'(k), 32'(ek[(c + 1) / 2]));
                chk("drive_status", {29'd0, busy, done, err}, 32'b100);
            end else begin
                chk("check_jk", {24'd0, j, k}, 32'd0);
                chk("check_status", {29'd0, busy, done, err}, 32'b100);
            end
        end
    endtask

    initial begin
        logic [W-1:0] t6;
        rst_n            = 1'b0;
        bank_clr         = 1'b1;
        stuck            = '0;
        u_if.tgt_valid   = 1'b0;
        u_if.tgt_data    = '0;
        u_if.toggle_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_jk", {24'd0, j, k}, 32'd0);
        chk("rst_status", {29'd0, busy, done, err}, 32'd0);
        chk("rst_ready", 32'(u_if.tgt_ready), 32'd1);
        rst_n    = 1'b1;
        bank_clr = 1'b0;

        xfer(4'b1010, 1'b0, 0);
        xfer(4'b0110, 1'b1, 0);
        xfer(4'b0110, 1'b0, 0);
        stuck = 4'b0001;
        xfer(4'b0001, 1'b0, 0);
        stuck = 4'b0000;
        @(negedge clk);
        xfer(4'b0011, 1'b0, 1);
        xfer(4'b1100, 1'b1, 0);

        // Reset during DRIVE must kill the transfer immediately
        @(negedge clk);
        t6               = ~bank_q;
        u_if.tgt_valid   = 1'b1;
        u_if.tgt_data    = t6;
        u_if.toggle_mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        u_if.tgt_valid = 1'b0;
        chk("r6_drive_j", 32'(j), 32'(t6));
        chk("r6_drive_k", 32'(k), 32'(bank_q));
        #2 rst_n = 1'b0;
        #1;
        chk("r6_async_jk", {24'd0, j, k}, 32'd0);
        chk("r6_async_status", {29'd0, busy, done, err}, 32'd0);
        chk("r6_async_ready", 32'(u_if.tgt_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("r6_held_status", {29'd0, busy, done, err}, 32'd0);
        end
        rst_n = 1'b1;
        chk("r6_ready_after", 32'(u_if.tgt_ready), 32'd1);
        xfer(4'b1111, 1'b0, 0);

        for (int r = 0; r < 30; r++) begin
            @(negedge clk);
            stuck = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            xfer(W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
            u_if.tgt_valid = 1'b0;
        end
        stuck = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/jk_target_driver.md
# jk_target_driver

Excitation driver for a bank of WIDTH J-K flip-flops (the team's `jkff`): accepts a target word over a valid/ready handshake and generates per-bit J/K commands. It reads back the bank's `q` outputs and retries until the bank matches the target or the retry budget runs out, then reports done or error. It sits between any block that wants to load a value into a JK register and the register itself, as the command side of the J/K interface.

## Interface
- `WIDTH`, default 4: number of flip-flops driven.
- `MAX_TRIES`, default 3: drive attempts (≥1) before declaring error.
- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tgt_valid` in 1: target word offered.
- `tgt_ready` out 1: driver can accept a target.
- `tgt_data` in WIDTH: target word.
- `toggle_mode` in 1: sampled with the target; selects toggle encoding.
- `q_in` in WIDTH: feedback from the flip-flop bank's `q`.
- `j` out WIDTH: J commands to the bank.
- `k` out WIDTH: K commands to the bank.
- `busy` out 1: high while not IDLE.
- `done` out 1: one-cycle pulse; bank matched the target.
- `err` out 1: one-cycle pulse; retries exhausted without a match.

## Operation
- States: IDLE, DRIVE, CHECK.
- IDLE:
  - `tgt_ready`=1, `j`=`k`=0.
  - On `tgt_valid && tgt_ready`: capture `tgt_data` and `toggle_mode`, clear the try counter, go to DRIVE.
- DRIVE (exactly one cycle): per bit, compare captured target t with `q_in` q.
  - q==t: j=0, k=0 (hold).
  - q=0, t=1: j=1, k=0 (set).
  - q=1, t=0: j=0, k=1 (reset).
  - With `toggle_mode`=1, every mismatched bit gets j=1, k=1 instead.
  - Increment the try counter. Go to CHECK.
- CHECK (one cycle): `j`=`k`=0; compare `q_in` to the target.
  - Match: go to IDLE and pulse `done`.
  - Mismatch with tries==MAX_TRIES: go to IDLE and pulse `err`.
  - Otherwise: go back to DRIVE.
- Try counter width is $clog2(MAX_TRIES+1). It must not wrap.
- `tgt_valid` outside IDLE is ignored; no queuing.
- `tgt_data` changes after acceptance have no effect.
- A target equal to the current `q_in` still takes one DRIVE cycle (all-zero j/k) and ends with `done`.

## Timing
- `j`, `k`, `done`, `err` are registered outputs. `tgt_ready` and `busy` decode from the state register.
- Cycle sequence, with acceptance at edge E0:
  - Cycle 1 (DRIVE): `j`/`k` valid. The bank samples them at edge E1.
  - Cycle 2 (CHECK): `q_in` reflects the updated bank.
  - Cycle 3: IDLE with `done` or `err` high and `tgt_ready`=1. A new target may be accepted at edge E3.
- Clean load latency, acceptance to `done`: 3 cycles. Each extra retry adds 2 cycles.
- Worst case to `err`: 2·MAX_TRIES+1 cycles.
- `done` and `err` are never both high. Each is high for exactly one cycle.
- Reset values while `rst_n`=0: state IDLE, `j`=`k`=0, `done`=`err`=0, `busy`=0, try counter 0, captured target 0.
  - `tgt_ready` is 1 once reset is held.
- Reset asserted mid-operation: outputs clear asynchronously the same instant. The transfer is abandoned with no `done`/`err` pulse.
- First acceptance possible at the first posedge after `rst_n` deasserts.

## Structure
- Shared package `jk_pkg` holds:
  - State enum (IDLE, DRIVE, CHECK).
  - 2-bit J/K command constants: HOLD=00, RESET=01, SET=10, TOGGLE=11.
- Sub-module `jk_excite`: combinational per-bit encoder (q, t, toggle_mode → {j,k}). Instantiated WIDTH times via generate.
- FSM, try counter and output registers live in the top.

## Test plan
Bench drives a 4-bit bank of `jkff` from `j`/`k` and feeds `q` back to `q_in`. Defaults: WIDTH=4, MAX_TRIES=3.
1. Reset, bank at 0000; load 1010 with `toggle_mode`=0.
   - DRIVE cycle: j=1010, k=0000.
   - `done` pulses in cycle 3; bank reads 1010.
2. From 1010, load 0110 with `toggle_mode`=1.
   - DRIVE cycle: j=k=1100.
   - `done` pulses in cycle 3; bank reads 0110.
3. Load 0110 while the bank already holds 0110.
   - One DRIVE cycle with j=k=0000, then `done`.
4. Bench forces `q_in` bit 0 stuck at 0; load 0001.
   - Three DRIVE cycles, each with j=0001.
   - `err` pulses in cycle 7; `done` never asserts.
5. Hold `tgt_valid` high with changing `tgt_data` during busy.
   - Only the first word is loaded. A second transfer is accepted exactly at the cycle-3 edge.
6. Assert `rst_n`=0 during the DRIVE cycle.
   - `j`/`k` go to 0 immediately; no `done`/`err`.
   - After release, `tgt_ready`=1 and a new load of 1111 completes normally.
